// File: rtl/cte_rgb2yuv422_stream.sv
// cte_rgb2yuv422_stream: RGB pixel stream to 4:2:2 YUV word stream (U,Y0,V,Y1), ready/valid on both sides.
// Ports: clk, reset (async active-low); in_valid/in_ready/rgb_in {R,G,B}/in_last;
// out_valid/out_ready/yuv_out/out_tag (0=U,1=Y0,2=V,3=Y1)/out_last (Y1 of final pair).
// Define CTE_CHROMA_AVG_EN to average U/V over both pixels of a pair instead of taking the even pixel.
module cte_rgb2yuv422_stream #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3*W-1:0] rgb_in,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   yuv_out,
  output logic [1:0]     out_tag,
  output logic           out_last
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 2;
  localparam int SW = W + 11;
  localparam int EW = 4 * W + 1;
  localparam logic [2:0] S_U = 3'd0, S_Y0 = 3'd1, S_V = 3'd2, S_Y1 = 3'd3, IDLE = 3'd4;
  localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEP = CW'(DEPTH);
  localparam logic signed [SW-1:0] HALF = SW'(128);
  localparam logic signed [SW-1:0] HALF2 = SW'(256);
  localparam logic signed [SW-1:0] YMAX = SW'((1 << W) - 1);
  localparam logic signed [SW-1:0] CMAX = SW'((1 << (W - 1)) - 1);
  localparam logic signed [SW-1:0] CMIN = SW'(-(1 << (W - 1)));
  typedef logic [2:0][W+9:0] prod_t;
  function automatic prod_t mul3(input logic [3*W-1:0] p, input logic signed [9:0] kr, kg, kb);
    logic signed [W+9:0] r, g, b;
    r = {10'b0, p[3*W-1:2*W]};
    g = {10'b0, p[2*W-1:W]};
    b = {10'b0, p[W-1:0]};
    return {r * kr, g * kg, b * kb};
  endfunction
  function automatic logic signed [SW-1:0] sum3(input prod_t p);
    return SW'($signed(p[2])) + SW'($signed(p[1])) + SW'($signed(p[0]));
  endfunction
  function automatic logic [W-1:0] sat_y(input logic signed [SW-1:0] r);
    return r[SW-1] ? '0 : (r > YMAX) ? YMAX[W-1:0] : r[W-1:0];
  endfunction
  function automatic logic [W-1:0] sat_c(input logic signed [SW-1:0] r);
    return (r < CMIN) ? CMIN[W-1:0] : (r > CMAX) ? CMAX[W-1:0] : r[W-1:0];
  endfunction
  logic           alive, has_even, v1, l1, v2;
  logic [3*W-1:0] even_px, pe_px;
  prod_t          pye, pue, pve, pyo;
`ifdef CTE_CHROMA_AVG_EN
  prod_t          puo, pvo;
`endif
  logic [W-1:0]   cu, cv;
  logic [EW-1:0]  d2, head;
  logic [EW-1:0]  mem [DEPTH];
  logic [PW-1:0]  wp, rp;
  logic [CW-1:0]  count, occ;
  logic [2:0]     state;
  logic           acc, launch, pop;
  // A pending even pixel already holds its pair slot, so its odd partner is always accepted.
  assign occ = count + CW'(v1) + CW'(v2);
  assign in_ready = alive & (has_even | (occ < DEP));
  assign acc = in_valid & in_ready;
  assign launch = acc & (has_even | in_last);
  assign pe_px = has_even ? even_px : rgb_in;
  assign pop = out_valid & out_ready & (state == S_Y1);
`ifdef CTE_CHROMA_AVG_EN
  assign cu = sat_c((sum3(pue) + sum3(puo) + HALF2) >>> 9);
  assign cv = sat_c((sum3(pve) + sum3(pvo) + HALF2) >>> 9);
`else
  assign cu = sat_c((sum3(pue) + HALF) >>> 8);
  assign cv = sat_c((sum3(pve) + HALF) >>> 8);
`endif
  assign head = mem[rp];
  assign out_valid = ~state[2];
  assign out_tag = state[1:0];
  assign out_last = (state == S_Y1) & head[EW-1];
  assign yuv_out = !out_valid ? '0 : (out_tag == 2'd0) ? head[3*W +: W] :
                   (out_tag == 2'd1) ? head[2*W +: W] : (out_tag == 2'd2) ? head[W +: W] : head[0 +: W];
  always_ff @(posedge clk) begin
    if (v2) mem[wp] <= d2;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive <= 1'b0;
      has_even <= 1'b0;
      even_px <= '0;
      v1 <= 1'b0;
      l1 <= 1'b0;
      pye <= '0;
      pue <= '0;
      pve <= '0;
      pyo <= '0;
`ifdef CTE_CHROMA_AVG_EN
      puo <= '0;
      pvo <= '0;
`endif
      v2 <= 1'b0;
      d2 <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      state <= IDLE;
    end else begin
      alive <= 1'b1;
      if (acc) begin
        has_even <= ~has_even & ~in_last;
        if (!has_even) even_px <= rgb_in;
      end
      v1 <= launch;
      if (launch) begin
        l1 <= in_last;
        pye <= mul3(pe_px, 10'sd77, 10'sd150, 10'sd29);
        pue <= mul3(pe_px, -10'sd43, -10'sd85, 10'sd128);
        pve <= mul3(pe_px, 10'sd128, -10'sd107, -10'sd21);
        pyo <= mul3(rgb_in, 10'sd77, 10'sd150, 10'sd29);
`ifdef CTE_CHROMA_AVG_EN
        puo <= mul3(rgb_in, -10'sd43, -10'sd85, 10'sd128);
        pvo <= mul3(rgb_in, 10'sd128, -10'sd107, -10'sd21);
`endif
      end
      v2 <= v1;
      if (v1) d2 <= {l1, cu, sat_y((sum3(pye) + HALF) >>> 8), cv, sat_y((sum3(pyo) + HALF) >>> 8)};
      if (v2) wp <= (wp == PLAST) ? '0 : wp + 1'b1;
      if (pop) rp <= (rp == PLAST) ? '0 : rp + 1'b1;
      count <= count + CW'(v2) - CW'(pop);
      // A pair pushed while the last one pops continues straight into S_U without a bubble.
      state <= (state == IDLE) ? ((count != '0) ? S_U : IDLE) :
               !out_ready ? state :
               (state != S_Y1) ? state + 3'd1 :
               ((count > CW'(1)) || v2) ? S_U : IDLE;
    end
  end
endmodule

// File: tb/tb_cte_rgb2yuv422_stream.sv
// tb_cte_rgb2yuv422_stream: scoreboard bench for cte_rgb2yuv422_stream (W=8, DEPTH=4).
module tb_cte_rgb2yuv422_stream;
  localparam int W = 8;
  localparam int DEPTH = 4;
  typedef logic [10:0] ent_t;
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic fix_rdy = 1'b0, rnd_mode = 1'b0, rnd_bit = 1'b0;
  logic [23:0] rgb_in = '0;
  logic in_ready, out_valid, out_ready, out_last;
  logic [7:0] yuv_out;
  logic [1:0] out_tag;
  int checks = 0, failures = 0, m_resv = 0, m_pops = 0;
  logic m_held = 1'b0, auto_exp = 1'b0;
  logic [23:0] m_even = '0;
  ent_t expq[$];
  assign out_ready = rnd_mode ? rnd_bit : fix_rdy;
  always #5 clk = ~clk;
  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
  cte_rgb2yuv422_stream #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .rgb_in(rgb_in),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .yuv_out(yuv_out),
    .out_tag(out_tag), .out_last(out_last)
  );
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask
  function automatic logic [7:0] cy(input int s);
    int r;
    r = (s + 128) >>> 8;
    return (r < 0) ? 8'h00 : (r > 255) ? 8'hFF : r[7:0];
  endfunction
  function automatic logic [7:0] cc(input int r);
    return (r < -128) ? 8'h80 : (r > 127) ? 8'h7F : r[7:0];
  endfunction
  task automatic exp4(input logic [7:0] u, y0, v, y1);
    expq.push_back({u, 2'd0, 1'b0});
    expq.push_back({y0, 2'd1, 1'b0});
    expq.push_back({v, 2'd2, 1'b0});
    expq.push_back({y1, 2'd3, 1'b1});
  endtask
  task automatic push_pair(input logic [23:0] e, input logic [23:0] o, input logic l);
    int er, eg, eb, orr, og, ob, ue, ve, uo, vo;
    logic [7:0] u, v;
    er = int'(e[23:16]); eg = int'(e[15:8]); eb = int'(e[7:0]);
    orr = int'(o[23:16]); og = int'(o[15:8]); ob = int'(o[7:0]);
    ue = -43 * er - 85 * eg + 128 * eb;
    ve = 128 * er - 107 * eg - 21 * eb;
    uo = -43 * orr - 85 * og + 128 * ob;
    vo = 128 * orr - 107 * og - 21 * ob;
`ifdef CTE_CHROMA_AVG_EN
    u = cc((ue + uo + 256) >>> 9);
    v = cc((ve + vo + 256) >>> 9);
`else
    u = cc((ue + 128) >>> 8);
    v = cc((ve + 128) >>> 8);
    if (uo == vo + 1) u = u;
`endif
    expq.push_back({u, 2'd0, 1'b0});
    expq.push_back({cy(77 * er + 150 * eg + 29 * eb), 2'd1, 1'b0});
    expq.push_back({v, 2'd2, 1'b0});
    expq.push_back({cy(77 * orr + 150 * og + 29 * ob), 2'd3, l});
  endtask
  task automatic send(input logic [23:0] p, input logic l);
    int n;
    @(negedge clk);
    in_valid = 1'b1; rgb_in = p; in_last = l; n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout got=0 exp=1 pixel=%06h", p);
    end else begin
      @(posedge clk);
      if (!m_held) begin
        m_resv++;
        if (l) begin
          if (auto_exp) push_pair(p, p, 1'b1);
        end else begin
          m_held = 1'b1; m_even = p;
        end
      end else begin
        m_held = 1'b0;
        if (auto_exp) push_pair(m_even, p, l);
      end
    end
    #1 in_valid = 1'b0; in_last = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", expq.size(), 0);
    @(posedge clk);
    #1 chk("idle_after_drain", out_valid, 0);
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_valid"}, out_valid, 0);
    chk({n, "_yuv"}, yuv_out, 0);
    chk({n, "_tag"}, out_tag, 0);
    chk({n, "_last"}, out_last, 0);
    chk({n, "_in_ready"}, in_ready, 0);
  endtask
  task automatic reset_pulse(input string n);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 chk_zero(n);
    @(posedge clk);
    #1 reset = 1'b1;
    m_held = 1'b0;
    m_resv = m_pops;
  endtask
  always @(negedge clk) begin
    static logic hold_v = 1'b0;
    static ent_t hold_w = '0;
    ent_t got, e;
    got = {yuv_out, out_tag, out_last};
    if (!reset) begin
      hold_v = 1'b0;
      expq.delete();
    end else begin
      if (in_ready) begin
        checks++;
        if (!m_held && (m_resv - m_pops) >= DEPTH) begin
          failures++;
          $display("FAIL credit in_ready=1 exp=0 pairs=%0d", m_resv - m_pops);
        end
      end
      if (hold_v) begin
        checks++;
        if (!out_valid || got !== hold_w) begin
          failures++;
          $display("FAIL stall_hold got=%0b/%03h exp=1/%03h", out_valid, got, hold_w);
        end
      end
      hold_v = out_valid && !out_ready;
      hold_w = got;
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word got=%02h tag=%0d last=%0b exp=none", yuv_out, out_tag, out_last);
        end else begin
          e = expq.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL word got=%02h/t%0d/l%0b exp=%02h/t%0d/l%0b", yuv_out, out_tag, out_last, e[10:3], e[2:1], e[0]);
          end
          if (e[2:1] == 2'd3) m_pops++;
        end
      end
    end
  end
  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    ent_t e;
    logic [23:0] p;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    #1 chk("in_ready_pre_edge", in_ready, 0);
    @(posedge clk);
    #1 chk("in_ready_post_edge", in_ready, 1);
    fix_rdy = 1'b1;
    exp4(8'h00, 8'hFF, 8'h00, 8'hFF);
    send(24'hFFFFFF, 1'b1);
    repeat (2) @(posedge clk);
    #1 chk("latency_edge2", out_valid, 0);
    @(posedge clk);
    #1 chk("latency_edge3", out_valid, 1);
    drain();
`ifdef CTE_CHROMA_AVG_EN
    exp4(8'h2A, 8'h4D, 8'h35, 8'h1D);
`else
    exp4(8'hD5, 8'h4D, 8'h7F, 8'h1D);
`endif
    send(24'hFF0000, 1'b0);
    send(24'h0000FF, 1'b1);
    drain();
    auto_exp = 1'b1;
    fix_rdy = 1'b0;
    for (int i = 0; i < 2 * DEPTH; i++) send({8'(i * 37), 8'(255 - i * 20), 8'(i * 60)}, 1'b0);
    repeat (4) @(negedge clk);
    e = expq[0];
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_tag", out_tag, 0);
    chk("bp_first_u", yuv_out, e[10:3]);
    fork
      begin
        send(24'h80FF10, 1'b0);
        send(24'h0180FE, 1'b1);
      end
      begin
        repeat (10) @(posedge clk);
        #1 fix_rdy = 1'b1;
      end
    join
    drain();
    auto_exp = 1'b0;
    send(24'h123456, 1'b0);
    reset_pulse("rst_mid_pair");
    exp4(8'h00, 8'hFF, 8'h00, 8'h00);
    send(24'hFFFFFF, 1'b0);
    send(24'h000000, 1'b1);
    drain();
    fix_rdy = 1'b0;
    send(24'hFF0000, 1'b0);
    send(24'h0000FF, 1'b1);
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    chk("stall_before_reset", out_valid, 1);
    reset_pulse("rst_mid_serial");
    fix_rdy = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk("no_stale_words", out_valid, 0);
    exp4(8'h00, 8'hFF, 8'h00, 8'hFF);
    send(24'hFFFFFF, 1'b1);
    drain();
    auto_exp = 1'b1;
    rnd_mode = 1'b1;
    for (int i = 0; i < 500; i++) begin
      p = 24'($urandom());
      send(p, (i == 499) || ($urandom_range(0, 19) == 0));
    end
    drain();
    rnd_mode = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
